// File: rtl/fir_serial_mac.sv
// Serial FIR filter: one shared multiplier walks the taps, then rounds and saturates the sum.
// Latency: out_valid rises N_TAPS+2 cycles after acceptance; one sample per N_TAPS+3 cycles at best.
// Backpressure: in_ready only in IDLE; the result holds in OUT until out_ready, stalling the input.
//
// Ports:
//   clk, reset                     - single clock, synchronous active-high reset
//   in_data/in_valid/in_ready      - sample input handshake (signed DATA_W)
//   out_data/out_sat/out_valid/out_ready - result handshake, out_sat flags a clamped result
//   coef_wr_en/coef_wr_addr/coef_wr_data - coefficient write port (signed Q1.(COEF_W-1))
module fir_serial_mac #(
   parameter int DATA_W = 24,
   parameter int COEF_W = 16,
   parameter int N_TAPS = 9
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_sat,
   input  logic                      coef_wr_en,
   input  logic [$clog2(N_TAPS)-1:0] coef_wr_addr,
   input  logic [COEF_W-1:0]         coef_wr_data
);

   localparam int IDX_W  = $clog2(N_TAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + IDX_W;
   // One spare bit so adding the rounding constant can never overflow.
   localparam int RND_W  = ACC_W + 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TAPS - 1);
   localparam logic [IDX_W:0]   N_TAPS_V = (IDX_W + 1)'(N_TAPS);
   localparam logic [RND_W-1:0] RND_K    = {{(RND_W-1){1'b0}}, 1'b1} << (COEF_W - 2);
   localparam logic signed [RND_W-1:0] SAT_MAX = {{(RND_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [RND_W-1:0] SAT_MIN = {{(RND_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      ROUND = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t                   state_q;
   logic signed [DATA_W-1:0] x_q [N_TAPS];
   logic signed [COEF_W-1:0] c_q [N_TAPS];
   logic [ACC_W-1:0]         acc_q;
   logic [IDX_W-1:0]         idx_q;
   logic [DATA_W-1:0]        out_data_q;
   logic                     out_sat_q;
   logic                     out_valid_q;
   logic                     in_ready_q;

   // Shared multiplier: both operands sign-extended to the full product width.
   logic signed [COEF_W-1:0] c_sel;
   logic signed [DATA_W-1:0] x_sel;
   logic signed [PROD_W-1:0] c_ext;
   logic signed [PROD_W-1:0] x_ext;
   logic signed [PROD_W-1:0] prod;
   logic [ACC_W-1:0]         acc_d;

   assign c_sel = c_q[idx_q];
   assign x_sel = x_q[idx_q];
   assign c_ext = {{DATA_W{c_sel[COEF_W-1]}}, c_sel};
   assign x_ext = {{COEF_W{x_sel[DATA_W-1]}}, x_sel};
   assign prod  = c_ext * x_ext;
   assign acc_d = acc_q + {{IDX_W{prod[PROD_W-1]}}, prod};

   // Round half up, then clamp into the output range.
   logic signed [RND_W-1:0] rnd_sum;
   logic signed [RND_W-1:0] rnd_shift;
   logic [DATA_W-1:0]       res_d;
   logic                    sat_d;

   assign rnd_sum   = {acc_q[ACC_W-1], acc_q} + RND_K;
   assign rnd_shift = rnd_sum >>> (COEF_W - 1);

   always_comb begin
      res_d = rnd_shift[DATA_W-1:0];
      sat_d = 1'b0;
      if (rnd_shift > SAT_MAX) begin
         res_d = SAT_MAX[DATA_W-1:0];
         sat_d = 1'b1;
      end else if (rnd_shift < SAT_MIN) begin
         res_d = SAT_MIN[DATA_W-1:0];
         sat_d = 1'b1;
      end
   end

   // Coefficients are only read during MAC, so writes are locked out there
   // and accepted everywhere else; the result register is never touched.
   logic coef_we;
   assign coef_we = coef_wr_en && (state_q != MAC) && ({1'b0, coef_wr_addr} < N_TAPS_V);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         idx_q       <= '0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         for (int k = 0; k < N_TAPS; k++) begin
            x_q[k] <= '0;
            c_q[k] <= '0;
         end
      end else begin
         if (coef_we) begin
            c_q[coef_wr_addr] <= coef_wr_data;
         end
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  for (int k = N_TAPS - 1; k > 0; k--) begin
                     x_q[k] <= x_q[k-1];
                  end
                  x_q[0]     <= in_data;
                  acc_q      <= '0;
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= MAC;
               end
            end
            MAC: begin
               acc_q <= acc_d;
               idx_q <= idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_q <= ROUND;
               end
            end
            ROUND: begin
               out_data_q  <= res_d;
               out_sat_q   <= sat_d;
               out_valid_q <= 1'b1;
               state_q     <= OUT;
            end
            OUT: begin
               // Returning to IDLE first keeps the output handshake and the
               // next acceptance in separate cycles.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
module tb_fir_serial_mac;

   localparam int NT = 9;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_sat;
   logic        coef_wr_en;
   logic [3:0]  coef_wr_addr;
   logic [15:0] coef_wr_data;

   int total = 0;
   int bad   = 0;

   fir_serial_mac #(.DATA_W(24), .COEF_W(16), .N_TAPS(NT)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sat      (out_sat),
      .coef_wr_en   (coef_wr_en),
      .coef_wr_addr (coef_wr_addr),
      .coef_wr_data (coef_wr_data)
   );

   always #5 clk = ~clk;

   // Reference model: coefficient table and sample history, evaluated as a plain dot product.
   logic signed [15:0] m_c [NT];
   logic signed [23:0] m_x [NT];

   localparam longint YMAX = (longint'(1) <<< 23) - 1;
   localparam longint YMIN = -(longint'(1) <<< 23);

   function automatic void model_clear();
      for (int k = 0; k < NT; k++) begin
         m_c[k] = '0;
         m_x[k] = '0;
      end
   endfunction

   function automatic void model_push(input logic [23:0] d);
      for (int k = NT - 1; k > 0; k--) m_x[k] = m_x[k-1];
      m_x[0] = d;
   endfunction

   function automatic void model_calc(output logic [23:0] y, output logic s);
      longint acc = 0;
      longint r;
      for (int k = 0; k < NT; k++) acc += longint'(m_c[k]) * longint'(m_x[k]);
      r = (acc + 64'sd16384) >>> 15;
      if (r > YMAX) begin
         y = 24'h7FFFFF; s = 1'b1;
      end else if (r < YMIN) begin
         y = 24'h800000; s = 1'b1;
      end else begin
         y = r[23:0]; s = 1'b0;
      end
   endfunction

   // All stimulus tasks start and end just after a falling edge.
   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; coef_wr_en = 1'b0; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      model_clear();
   endtask

   task automatic write_coef(input logic [3:0] a, input logic [15:0] d);
      coef_wr_en = 1'b1; coef_wr_addr = a; coef_wr_data = d;
      @(posedge clk); @(negedge clk);
      coef_wr_en = 1'b0;
   endtask

   task automatic load_random_coefs();
      for (int k = 0; k < NT; k++) begin
         m_c[k] = 16'($urandom);
         write_coef(4'(k), m_c[k]);
      end
   endtask

   // Sends one sample with out_ready=1; optionally issues a coefficient write in
   // cycle wr_cyc after acceptance (cycle 1 = first MAC cycle). lat=-1 on timeout.
   task automatic run_sample(input logic [23:0] d, input int wr_cyc, input logic [3:0] wa,
                             input logic [15:0] wd, output logic [23:0] od,
                             output logic osat, output int lat);
      in_data = d; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; in_data = 24'($urandom);
      lat = -1; od = '0; osat = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         coef_wr_en = (i == wr_cyc); coef_wr_addr = wa; coef_wr_data = wd;
         if (out_valid) begin
            od = out_data; osat = out_sat; lat = i;
            break;
         end
         @(posedge clk); @(negedge clk);
      end
      if (lat > 0) begin
         @(posedge clk); @(negedge clk);
      end
      coef_wr_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [23:0] od, ey; logic os, es; int lat;
      // Reset held over a concurrent sample and coefficient write: both must lose.
      reset = 1'b1; in_valid = 1'b1; in_data = 24'h100000; out_ready = 1'b1;
      coef_wr_en = 1'b1; coef_wr_addr = 4'd0; coef_wr_data = 16'h4000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0; coef_wr_en = 1'b0;
      model_clear();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (out_data !== 24'h0) begin bad++; $display("FAIL reset_out_data: got %h want 000000", out_data); end
      total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
      run_sample(24'h100000, -1, 4'd0, 16'h0, od, os, lat);
      model_push(24'h100000); model_calc(ey, es);
      total++; if (od !== ey || os !== es) begin bad++; $display("FAIL reset_first_out: got %h/%b want %h/%b", od, os, ey, es); end
   endtask

   task automatic test_gain();
      logic [23:0] od, ey; logic os, es; int lat;
      do_reset();
      write_coef(4'd0, 16'h4000); m_c[0] = 16'h4000;
      run_sample(24'h100000, -1, 4'd0, 16'h0, od, os, lat);
      model_push(24'h100000); model_calc(ey, es);
      total++; if (od !== 24'h080000) begin bad++; $display("FAIL gain_data: got %h want 080000", od); end
      total++; if (od !== ey) begin bad++; $display("FAIL gain_model: got %h want %h", od, ey); end
      total++; if (os !== 1'b0) begin bad++; $display("FAIL gain_sat: got %b want 0", os); end
      total++; if (lat !== 11) begin bad++; $display("FAIL gain_latency: got %0d want 11", lat); end
   endtask

   task automatic test_impulse();
      logic [23:0] od, ey, d; logic os, es; int lat;
      do_reset();
      for (int k = 0; k < NT; k++) begin
         m_c[k] = 16'(k + 1);
         write_coef(4'(k), m_c[k]);
      end
      for (int n = 0; n < NT; n++) begin
         d = (n == 0) ? 24'h008000 : 24'h0;
         run_sample(d, -1, 4'd0, 16'h0, od, os, lat);
         model_push(d); model_calc(ey, es);
         total++; if (od !== 24'(n + 1)) begin bad++; $display("FAIL impulse_tap[%0d]: got %h want %h", n, od, 24'(n + 1)); end
         total++; if (od !== ey || os !== es) begin bad++; $display("FAIL impulse_model[%0d]: got %h/%b want %h/%b", n, od, os, ey, es); end
         total++; if (lat !== 11) begin bad++; $display("FAIL impulse_latency[%0d]: got %0d want 11", n, lat); end
      end
   endtask

   task automatic test_saturation();
      logic [23:0] od, ey, p; logic os, es; int lat;
      do_reset();
      for (int k = 0; k < NT; k++) begin
         m_c[k] = 16'h7FFF;
         write_coef(4'(k), 16'h7FFF);
      end
      for (int pass = 0; pass < 2; pass++) begin
         p = (pass == 0) ? 24'h7FFFFF : 24'h800000;
         for (int n = 0; n < NT; n++) begin
            run_sample(p, -1, 4'd0, 16'h0, od, os, lat);
            model_push(p); model_calc(ey, es);
            total++; if (od !== ey || os !== es) begin bad++; $display("FAIL sat_model[%0d.%0d]: got %h/%b want %h/%b", pass, n, od, os, ey, es); end
            if (n == NT - 1) begin
               total++; if (od !== p || os !== 1'b1) begin bad++; $display("FAIL sat_final[%0d]: got %h/%b want %h/1", pass, od, os, p); end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [23:0] od, ey, d; logic os, es; int lat;
      logic [15:0] nc;
      do_reset();
      load_random_coefs();
      d = 24'($urandom);
      in_data = d; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      model_push(d); model_calc(ey, es);
      lat = -1;
      // in_valid stays high with junk data throughout; none of it may be taken.
      for (int i = 1; i <= 40; i++) begin
         in_data = 24'($urandom);
         if (out_valid) begin lat = i; break; end
         @(posedge clk); @(negedge clk);
      end
      total++; if (lat !== 11) begin bad++; $display("FAIL bp_latency: got %0d want 11", lat); end
      nc = 16'($urandom);
      for (int h = 0; h < 5; h++) begin
         total++; if (out_data !== ey || out_sat !== es) begin bad++; $display("FAIL bp_hold[%0d]: got %h/%b want %h/%b", h, out_data, out_sat, ey, es); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", h, in_ready); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", h, out_valid); end
         // Coefficient write while the result is pending in OUT.
         coef_wr_en = (h == 2); coef_wr_addr = 4'd0; coef_wr_data = nc;
         @(posedge clk); @(negedge clk);
      end
      coef_wr_en = 1'b0;
      m_c[0] = nc;
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
      in_valid = 1'b0;
      d = 24'($urandom);
      run_sample(d, -1, 4'd0, 16'h0, od, os, lat);
      model_push(d); model_calc(ey, es);
      total++; if (od !== ey || os !== es) begin bad++; $display("FAIL bp_next: got %h/%b want %h/%b", od, os, ey, es); end
   endtask

   task automatic test_coef_rules();
      logic [23:0] od, ey, d; logic os, es; int lat;
      logic [15:0] nc;
      do_reset();
      load_random_coefs();
      // Write during MAC: ignored for this sample and the next.
      d = 24'($urandom);
      run_sample(d, 3, 4'd0, m_c[0] ^ 16'h4000, od, os, lat);
      model_push(d); model_calc(ey, es);
      total++; if (od !== ey || os !== es) begin bad++; $display("FAIL coef_mac_write: got %h/%b want %h/%b", od, os, ey, es); end
      d = 24'($urandom);
      run_sample(d, -1, 4'd0, 16'h0, od, os, lat);
      model_push(d); model_calc(ey, es);
      total++; if (od !== ey || os !== es) begin bad++; $display("FAIL coef_mac_after: got %h/%b want %h/%b", od, os, ey, es); end
      // Out-of-range address: no coefficient changes.
      write_coef(4'd9, 16'h1234);
      d = 24'($urandom);
      run_sample(d, -1, 4'd0, 16'h0, od, os, lat);
      model_push(d); model_calc(ey, es);
      total++; if (od !== ey || os !== es) begin bad++; $display("FAIL coef_addr9: got %h/%b want %h/%b", od, os, ey, es); end
      // Write in ROUND: result of this sample unchanged, next sample uses it.
      nc = m_c[1] ^ 16'h2000;
      d = 24'($urandom);
      run_sample(d, 10, 4'd1, nc, od, os, lat);
      model_push(d); model_calc(ey, es);
      total++; if (od !== ey || os !== es) begin bad++; $display("FAIL coef_round_pending: got %h/%b want %h/%b", od, os, ey, es); end
      m_c[1] = nc;
      d = 24'($urandom);
      run_sample(d, -1, 4'd0, 16'h0, od, os, lat);
      model_push(d); model_calc(ey, es);
      total++; if (od !== ey || os !== es) begin bad++; $display("FAIL coef_round_applied: got %h/%b want %h/%b", od, os, ey, es); end
   endtask

   task automatic test_reset_mid();
      logic [23:0] od, ey, d; logic os, es; int lat;
      do_reset();
      load_random_coefs();
      in_data = 24'($urandom) | 24'h1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      for (int i = 1; i < 5; i++) begin
         @(posedge clk); @(negedge clk);
      end
      // Now in the MAC cycle working on tap 4.
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      model_clear();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
      d = 24'($urandom) | 24'h400000;
      run_sample(d, -1, 4'd0, 16'h0, od, os, lat);
      model_push(d); model_calc(ey, es);
      total++; if (od !== 24'h0 || od !== ey || os !== es) begin bad++; $display("FAIL midrst_out: got %h/%b want %h/%b", od, os, ey, es); end
      total++; if (lat !== 11) begin bad++; $display("FAIL midrst_latency: got %0d want 11", lat); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] od, ey, d; logic os, es; int lat;
      int sel;
      do_reset();
      load_random_coefs();
      for (int n = 0; n < 24; n++) begin
         if (n % 6 == 5) begin
            sel = $urandom_range(0, NT - 1);
            m_c[sel] = 16'($urandom);
            write_coef(4'(sel), m_c[sel]);
         end
         sel = $urandom_range(0, 5);
         d = (sel == 0) ? 24'h7FFFFF : (sel == 1) ? 24'h800000 : 24'($urandom);
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", n, in_ready); end
         run_sample(d, -1, 4'd0, 16'h0, od, os, lat);
         model_push(d); model_calc(ey, es);
         total++; if (od !== ey || os !== es) begin bad++; $display("FAIL b2b_out[%0d]: got %h/%b want %h/%b", n, od, os, ey, es); end
         total++; if (lat !== 11) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want 11", n, lat); end
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
      model_clear();
      @(negedge clk);
      test_reset();
      test_gain();
      test_impulse();
      test_saturation();
      test_backpressure();
      test_coef_rules();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fir_serial_mac.md
FIR_SERIAL_MAC -- requirements
Module: fir_serial_mac

Interface
REQ-001 Parameter DATA_W, default 24: sample width, signed two's complement.
REQ-002 Parameter COEF_W, default 16: coefficient width, signed Q1.(COEF_W-1).
REQ-003 Parameter N_TAPS, default 9: tap count, legal range 2..64.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port in_data  input  DATA_W: input sample.
REQ-007 Port in_valid  input  1: in_data is valid.
REQ-008 Port in_ready  output  1: block can accept a sample.
REQ-009 Port out_data  output  DATA_W: filtered sample.
REQ-010 Port out_valid  output  1: out_data is valid.
REQ-011 Port out_ready  input  1: downstream accepts out_data.
REQ-012 Port out_sat  output  1: out_data was saturated; qualified by out_valid.
REQ-013 Port coef_wr_en  input  1: coefficient write strobe.
REQ-014 Port coef_wr_addr  input  $clog2(N_TAPS): tap index to write.
REQ-015 Port coef_wr_data  input  COEF_W: coefficient value.

Function
REQ-016 The filter SHALL compute y = sum over k=0..N_TAPS-1 of c[k]*x[k]. x[0] is the newest accepted sample and x[k] is the sample accepted k samples earlier.
REQ-017 The block SHALL use one multiplier, time-shared across taps, one tap per cycle.
REQ-018 The FSM SHALL have four states: IDLE, MAC, ROUND and OUT.
REQ-019 Transitions: IDLE->MAC on in_valid&&in_ready; MAC->ROUND after N_TAPS MAC cycles; ROUND->OUT unconditionally; OUT->IDLE on out_ready.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 On acceptance, the delay line SHALL shift (x[k]<=x[k-1], x[0]<=in_data), the accumulator SHALL clear and the tap index SHALL clear to 0.
REQ-022 Each MAC cycle SHALL perform acc <= acc + c[idx]*x[idx], then idx <= idx+1, for idx = 0..N_TAPS-1 in order.
REQ-023 Product width SHALL be DATA_W+COEF_W; accumulator width SHALL be DATA_W+COEF_W+$clog2(N_TAPS); the accumulator SHALL never wrap.
REQ-024 In ROUND, the block SHALL add 2^(COEF_W-2) to acc and arithmetic-shift right by COEF_W-1 (round half up).
REQ-025 The rounded value SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_sat SHALL be 1 iff clamping occurred.
REQ-026 The rounded and saturated result SHALL be registered into out_data/out_sat at the ROUND->OUT edge.
REQ-027 out_valid SHALL be 1 only in OUT. First assertion is N_TAPS+2 cycles after the acceptance edge.
REQ-028 While out_valid=1 and out_ready=0, out_data and out_sat SHALL hold stable.
REQ-029 A new sample SHALL NOT be accepted in the same cycle as the output handshake; throughput is one sample per N_TAPS+3 cycles minimum.
REQ-030 A coefficient write SHALL take effect at the next edge when coef_wr_en=1, the state is IDLE, ROUND or OUT, and coef_wr_addr<N_TAPS.
REQ-031 A coefficient write issued in MAC, or with coef_wr_addr>=N_TAPS, SHALL be ignored without side effect.
REQ-032 A coefficient write in ROUND or OUT SHALL NOT alter the pending out_data.

Reset
REQ-033 When reset=1 at an edge, the following SHALL clear regardless of state: state->IDLE, x[*]->0, c[*]->0, acc->0, idx->0, out_data->0, out_valid->0, out_sat->0.
REQ-034 The cycle after reset deasserts, in_ready SHALL be 1.
REQ-035 Reset SHALL take priority over every concurrent handshake or coefficient write.

Verification
REQ-036 Gain: c[0]=16'h4000, other taps 0; send 24'h100000 -> out_data=24'h080000, out_sat=0, out_valid rises 11 cycles after acceptance.
REQ-037 Impulse: load c[k]=k+1; send 24'h008000 then eight 0 samples -> outputs 1,2,...,9, each sign-extended to 24 bits.
REQ-038 Saturation: all c=16'h7FFF; send 24'h7FFFFF nine times -> ninth output 24'h7FFFFF, out_sat=1. Repeat with 24'h800000 -> 24'h800000, out_sat=1.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_data stable, in_ready=0, in_valid ignored; release -> IDLE next cycle.
REQ-040 Write during MAC to c[0] -> ignored; c[0] unchanged on the next sample. Write with coef_wr_addr=9 (N_TAPS=9) -> no coefficient changes.
REQ-041 Assert reset at MAC idx=4 -> next cycle IDLE, in_ready=1, out_valid=0; a subsequent sample with any data gives out_data=0 (coefficients cleared).
